// File: rtl/uart_tx_frame.sv
// AXI4-Stream to UART serializer: 5..9 data bits, none/even/odd/mark parity, 1 or 2 stop bits, line break.
// Define UART_TX_FIFO_EN to place a FIFO_DEPTH-entry input FIFO in front of the frame FSM.
module uart_tx_frame #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  output logic                          txd,
  output logic                          busy,
  output logic                          tx_done,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  input  logic [1:0]                    parity_mode,
  input  logic                          stop2,
  input  logic                          break_req,
  input  logic [15:0]                   prescale
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [3:0] LAST_IDX = 4'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP, ST_BREAK
  } state_t;

  function automatic logic [18:0] bit_reload(input logic [15:0] pre);
    logic [15:0] p;
    p = (pre == 16'd0) ? 16'd1 : pre;
    return {p, 3'b000} - 19'd1;
  endfunction

  function automatic logic parity_bit(input logic [1:0] mode, input logic [DATA_WIDTH-1:0] d);
    case (mode)
      2'b01:   parity_bit = ^d;
      2'b10:   parity_bit = ~(^d);
      2'b11:   parity_bit = 1'b1;
      default: parity_bit = 1'b0;
    endcase
  endfunction

  state_t                state_r, state_nxt_s;
  logic [18:0]           cnt_r, cnt_nxt_s, reload_r;
  logic [3:0]            idx_r, idx_nxt_s;
  logic                  brk_phase_r, brk_phase_nxt_s;
  logic [DATA_WIDTH-1:0] shreg_r, shreg_nxt_s;
  logic                  par_en_r, par_bit_r, stop2_r;
  logic                  txd_r, tx_done_r, busy_r, tready_r;
  logic                  txd_nxt_s, done_nxt_s;
  logic                  decide_s, start_s;
  logic                  push_s, word_avail_s, pending_nxt_s, tready_nxt_s;
  logic [DATA_WIDTH-1:0] word_s;
  logic [3:0]            last_stop_s;

  assign last_stop_s = stop2_r ? 4'd1 : 4'd0;
  assign push_s      = s_axis_tvalid && tready_r;

  // Frame sequencing; decide_s marks a point where a new frame or break may begin
  always_comb begin
    state_nxt_s     = state_r;
    cnt_nxt_s       = cnt_r;
    idx_nxt_s       = idx_r;
    brk_phase_nxt_s = brk_phase_r;
    shreg_nxt_s     = shreg_r;
    decide_s        = 1'b0;
    start_s         = 1'b0;
    case (state_r)
      ST_IDLE: decide_s = 1'b1;
      ST_START: begin
        if (cnt_r == 19'd0) begin
          state_nxt_s = ST_DATA;
          idx_nxt_s   = 4'd0;
          cnt_nxt_s   = reload_r;
        end else begin
          cnt_nxt_s = cnt_r - 19'd1;
        end
      end
      ST_DATA: begin
        if (cnt_r == 19'd0) begin
          cnt_nxt_s = reload_r;
          if (idx_r == LAST_IDX) begin
            idx_nxt_s   = 4'd0;
            state_nxt_s = par_en_r ? ST_PARITY : ST_STOP;
          end else begin
            idx_nxt_s   = idx_r + 4'd1;
            shreg_nxt_s = {1'b0, shreg_r[DATA_WIDTH-1:1]};
          end
        end else begin
          cnt_nxt_s = cnt_r - 19'd1;
        end
      end
      ST_PARITY: begin
        if (cnt_r == 19'd0) begin
          state_nxt_s = ST_STOP;
          idx_nxt_s   = 4'd0;
          cnt_nxt_s   = reload_r;
        end else begin
          cnt_nxt_s = cnt_r - 19'd1;
        end
      end
      ST_STOP: begin
        if (cnt_r == 19'd0) begin
          if (idx_r == last_stop_s) begin
            decide_s = 1'b1;
          end else begin
            idx_nxt_s = idx_r + 4'd1;
            cnt_nxt_s = reload_r;
          end
        end else begin
          cnt_nxt_s = cnt_r - 19'd1;
        end
      end
      ST_BREAK: begin
        if (!brk_phase_r) begin
          if (!break_req) begin
            brk_phase_nxt_s = 1'b1;
            cnt_nxt_s       = bit_reload(prescale);
          end else begin
            brk_phase_nxt_s = 1'b0;
          end
        end else if (cnt_r == 19'd0) begin
          state_nxt_s     = ST_IDLE;
          brk_phase_nxt_s = 1'b0;
        end else begin
          cnt_nxt_s = cnt_r - 19'd1;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
    if (decide_s) begin
      if (break_req) begin
        state_nxt_s     = ST_BREAK;
        brk_phase_nxt_s = 1'b0;
      end else if (word_avail_s) begin
        start_s     = 1'b1;
        state_nxt_s = ST_START;
        cnt_nxt_s   = bit_reload(prescale);
        idx_nxt_s   = 4'd0;
        shreg_nxt_s = word_s;
      end else begin
        state_nxt_s = ST_IDLE;
      end
    end else begin
      start_s = 1'b0;
    end
  end

  // Output values for the coming cycle, derived from next state so txd tracks the FSM without lag
  always_comb begin
    case (state_nxt_s)
      ST_IDLE:   txd_nxt_s = 1'b1;
      ST_START:  txd_nxt_s = 1'b0;
      ST_DATA:   txd_nxt_s = shreg_nxt_s[0];
      ST_PARITY: txd_nxt_s = par_bit_r;
      ST_STOP:   txd_nxt_s = 1'b1;
      ST_BREAK:  txd_nxt_s = brk_phase_nxt_s;
      default:   txd_nxt_s = 1'b1;
    endcase
    done_nxt_s = (state_nxt_s == ST_STOP) && (idx_nxt_s == last_stop_s) && (cnt_nxt_s == 19'd0);
  end

`ifdef UART_TX_FIFO_EN
  localparam int PTR_W = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_r, rd_ptr_r;
  logic [CNT_W-1:0]      count_r, count_nxt_s;

  assign word_avail_s  = (count_r != {CNT_W{1'b0}});
  assign word_s        = mem_r[rd_ptr_r];
  assign pending_nxt_s = (count_nxt_s != {CNT_W{1'b0}});
  assign tready_nxt_s  = (count_nxt_s != CNT_W'(FIFO_DEPTH)) && (state_nxt_s != ST_BREAK);
  assign fifo_count    = count_r;

  // Occupancy after this cycle's push/pop
  always_comb begin
    case ({push_s, start_s})
      2'b10:   count_nxt_s = count_r + {{(CNT_W-1){1'b0}}, 1'b1};
      2'b01:   count_nxt_s = count_r - {{(CNT_W-1){1'b0}}, 1'b1};
      default: count_nxt_s = count_r;
    endcase
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
    end else begin
      count_r <= count_nxt_s;
      if (push_s) wr_ptr_r <= wr_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
      if (start_s) rd_ptr_r <= rd_ptr_r + {{(PTR_W-1){1'b0}}, 1'b1};
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (push_s) mem_r[wr_ptr_r] <= s_axis_tdata;
  end
`else
  logic                  hold_valid_r, hold_valid_nxt_s;
  logic [DATA_WIDTH-1:0] hold_r;

  // A word handshaken in the same cycle a break wins is parked here rather than lost
  assign word_avail_s     = hold_valid_r || push_s;
  assign word_s           = hold_valid_r ? hold_r : s_axis_tdata;
  assign hold_valid_nxt_s = hold_valid_r ? !start_s : (push_s && !start_s);
  assign pending_nxt_s    = hold_valid_nxt_s;
  assign tready_nxt_s     = (state_nxt_s == ST_IDLE) && !break_req && !hold_valid_nxt_s;
  assign fifo_count       = {CNT_W{1'b0}};

  // Parked word register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_r <= 1'b0;
      hold_r       <= {DATA_WIDTH{1'b0}};
    end else begin
      hold_valid_r <= hold_valid_nxt_s;
      if (push_s && !start_s) hold_r <= s_axis_tdata;
    end
  end
`endif

  // FSM state, bit timer, frame configuration latches and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= 19'd0;
      reload_r    <= 19'd0;
      idx_r       <= 4'd0;
      brk_phase_r <= 1'b0;
      shreg_r     <= {DATA_WIDTH{1'b0}};
      par_en_r    <= 1'b0;
      par_bit_r   <= 1'b0;
      stop2_r     <= 1'b0;
      txd_r       <= 1'b1;
      tx_done_r   <= 1'b0;
      busy_r      <= 1'b0;
      tready_r    <= 1'b0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      idx_r       <= idx_nxt_s;
      brk_phase_r <= brk_phase_nxt_s;
      shreg_r     <= shreg_nxt_s;
      txd_r       <= txd_nxt_s;
      tx_done_r   <= done_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE) || pending_nxt_s;
      tready_r    <= tready_nxt_s;
      if (start_s) begin
        par_en_r  <= (parity_mode != 2'b00);
        par_bit_r <= parity_bit(parity_mode, word_s);
        stop2_r   <= stop2;
        reload_r  <= bit_reload(prescale);
      end
    end
  end

  assign txd           = txd_r;
  assign tx_done       = tx_done_r;
  assign busy          = busy_r;
  assign s_axis_tready = tready_r;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed self-checking bench for uart_tx_frame; FIFO scenario compiled in with UART_TX_FIFO_EN.
module tb_uart_tx_frame;

`ifdef UART_TX_FIFO_EN
  localparam int FD = 4;
`else
  localparam int FD = 16;
`endif

  logic                 clk = 1'b0;
  logic                 rst;
  logic [7:0]           s_axis_tdata;
  logic                 s_axis_tvalid;
  logic                 s_axis_tready;
  logic                 txd, busy, tx_done;
  logic [$clog2(FD):0]  fifo_count;
  logic [1:0]           parity_mode;
  logic                 stop2, break_req;
  logic [15:0]          prescale;

  int checks = 0;
  int errors = 0;

  uart_tx_frame #(.DATA_WIDTH(8), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
    .txd(txd), .busy(busy), .tx_done(tx_done), .fifo_count(fifo_count),
    .parity_mode(parity_mode), .stop2(stop2), .break_req(break_req), .prescale(prescale)
  );

  always #5 clk = ~clk;

  // Hand the word over; returns at the negedge of the first frame cycle
  task automatic send(input logic [7:0] d);
    int n;
    n = 0;
    @(negedge clk);
    s_axis_tdata  = d;
    s_axis_tvalid = 1'b1;
    while (s_axis_tready !== 1'b1 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= 1000) begin
      errors++;
      $display("FAIL send_timeout: tready=%b required 1", s_axis_tready);
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0;
`ifdef UART_TX_FIFO_EN
    @(negedge clk);
`endif
  endtask

  // Sample flen cycles of a frame against the hand-specified bit pattern
  task automatic check_frame(input string nm, input logic [7:0] d, input int has_par,
                             input logic pbit, input int flen, input int chg_at);
    logic [11:0] eb;
    int bad_txd, bad_busy, ndone, done_at, k;
    eb = 12'hFFF;
    eb[0] = 1'b0;
    for (int b = 0; b < 8; b++) eb[b+1] = d[b];
    if (has_par != 0) eb[9] = pbit;
    bad_txd = 0; bad_busy = 0; ndone = 0; done_at = -1;
    for (int i = 1; i <= flen; i++) begin
      k = (i - 1) / 8;
      if (txd !== eb[k]) bad_txd++;
      if (busy !== 1'b1) bad_busy++;
      if (tx_done === 1'b1) begin
        ndone++;
        done_at = i;
      end
      if (i == chg_at) begin
        parity_mode = ~parity_mode;
        stop2       = ~stop2;
      end
      @(negedge clk);
    end
    checks++;
    if (bad_txd != 0) begin
      errors++;
      $display("FAIL %s_txd: %0d wrong cycles, required 0", nm, bad_txd);
    end
    checks++;
    if (bad_busy != 0) begin
      errors++;
      $display("FAIL %s_busy: %0d cycles low, required 0", nm, bad_busy);
    end
    checks++;
    if (ndone != 1 || done_at != flen) begin
      errors++;
      $display("FAIL %s_done: %0d pulses last at %0d, required 1 at %0d", nm, ndone, done_at, flen);
    end
    checks++;
    if (txd !== 1'b1 || tx_done !== 1'b0) begin
      errors++;
      $display("FAIL %s_after: txd=%b tx_done=%b, required 1 0", nm, txd, tx_done);
    end
`ifndef UART_TX_FIFO_EN
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_busy: busy=%b required 0", nm, busy);
    end
`endif
  endtask

  task automatic test_reset();
    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tdata = 8'h00;
    parity_mode = 2'b00; stop2 = 1'b0; break_req = 1'b0; prescale = 16'd1;
    repeat (2) @(negedge clk);
    checks++;
    if (txd !== 1'b1 || s_axis_tready !== 1'b0 || busy !== 1'b0 || tx_done !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL reset_vals: txd=%b tready=%b busy=%b done=%b cnt=%0d, required 1 0 0 0 0",
               txd, s_axis_tready, busy, tx_done, fifo_count);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL reset_tready: tready=%b required 1", s_axis_tready);
    end
  endtask

  task automatic test_basic();
    send(8'hA5);
    check_frame("a5_8n1", 8'hA5, 0, 1'b0, 80, 0);
    prescale = 16'd0;
    send(8'h5A);
    check_frame("presc0", 8'h5A, 0, 1'b0, 80, 0);
    prescale = 16'd1;
  endtask

  task automatic test_parity();
    parity_mode = 2'b01;
    send(8'hA5);
    check_frame("even", 8'hA5, 1, 1'b0, 88, 0);
    parity_mode = 2'b10;
    send(8'hA5);
    check_frame("odd", 8'hA5, 1, 1'b1, 88, 0);
    parity_mode = 2'b11;
    stop2 = 1'b1;
    send(8'h00);
    check_frame("mark_s2", 8'h00, 1, 1'b1, 96, 20);
    parity_mode = 2'b00;
    stop2 = 1'b0;
  endtask

  task automatic test_break();
    int bad_lo, bad_hi;
    bad_lo = 0; bad_hi = 0;
    @(negedge clk);
    break_req = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (txd !== 1'b0 || s_axis_tready !== 1'b0) bad_lo++;
    end
    break_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (txd !== 1'b1 || s_axis_tready !== 1'b0) bad_hi++;
    end
    @(negedge clk);
    checks++;
    if (bad_lo != 0) begin
      errors++;
      $display("FAIL break_low: %0d bad cycles, required 0", bad_lo);
    end
    checks++;
    if (bad_hi != 0) begin
      errors++;
      $display("FAIL break_stop: %0d bad cycles, required 0", bad_hi);
    end
    checks++;
    if (s_axis_tready !== 1'b1) begin
      errors++;
      $display("FAIL break_release_tready: tready=%b required 1", s_axis_tready);
    end
    send(8'h3C);
    check_frame("post_break", 8'h3C, 0, 1'b0, 80, 0);
  endtask

  task automatic test_reset_mid();
    send(8'hFF);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if (txd !== 1'b1 || busy !== 1'b0 || tx_done !== 1'b0 || s_axis_tready !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset: txd=%b busy=%b done=%b tready=%b, required 1 0 0 0",
               txd, busy, tx_done, s_axis_tready);
    end
    @(negedge clk);
    rst = 1'b0;
    send(8'h96);
    check_frame("after_rst", 8'h96, 0, 1'b0, 80, 0);
  endtask

`ifdef UART_TX_FIFO_EN
  task automatic test_back_to_back();
    logic [7:0] words [5];
    logic       txs [700];
    int         dts [8];
    int         w, nd, peak, st, bad_sp, bad_dat;
    logic       acc, saw_full;
    logic [7:0] got;
    words[0] = 8'h11; words[1] = 8'h22; words[2] = 8'h33; words[3] = 8'h44; words[4] = 8'h55;
    w = 0; nd = 0; peak = 0; acc = 1'b0; saw_full = 1'b0; st = -1;
    for (int c = 0; c < 700; c++) begin
      @(negedge clk);
      txs[c] = txd;
      if (tx_done === 1'b1 && nd < 8) begin
        dts[nd] = c;
        nd++;
      end
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
      if (acc) w++;
      if (w < 5 && s_axis_tready === 1'b0) saw_full = 1'b1;
      s_axis_tvalid = (w < 5);
      if (w < 5) s_axis_tdata = words[w];
      acc = s_axis_tvalid && s_axis_tready;
    end
    s_axis_tvalid = 1'b0;
    checks++;
    if (w != 5) begin
      errors++;
      $display("FAIL b2b_accepted: %0d words, required 5", w);
    end
    checks++;
    if (peak < 3 || peak > 4 || !saw_full) begin
      errors++;
      $display("FAIL b2b_full: peak=%0d saw_full=%b, required 3..4 and 1", peak, saw_full);
    end
    checks++;
    if (nd != 5) begin
      errors++;
      $display("FAIL b2b_done_count: %0d pulses, required 5", nd);
    end
    bad_sp = 0;
    for (int i = 1; i < 5 && i < nd; i++) if (dts[i] - dts[i-1] != 80) bad_sp++;
    checks++;
    if (bad_sp != 0) begin
      errors++;
      $display("FAIL b2b_spacing: %0d gaps not 80, required 0", bad_sp);
    end
    for (int c = 0; c < 700 && st < 0; c++) if (txs[c] === 1'b0) st = c;
    bad_dat = 0;
    for (int f = 0; f < 5; f++) begin
      for (int b = 0; b < 8; b++) begin
        if (st >= 0 && st + 80*f + 8*b + 12 < 700) got[b] = txs[st + 80*f + 8*b + 12];
        else got[b] = 1'bx;
      end
      if (got !== words[f]) bad_dat++;
    end
    checks++;
    if (bad_dat != 0) begin
      errors++;
      $display("FAIL b2b_data: %0d frames wrong, required 0", bad_dat);
    end
    checks++;
    if (busy !== 1'b0 || fifo_count !== '0) begin
      errors++;
      $display("FAIL b2b_drain: busy=%b count=%0d, required 0 0", busy, fifo_count);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_basic();
    test_parity();
    test_break();
    test_reset_mid();
`ifdef UART_TX_FIFO_EN
    test_back_to_back();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
- AXI4-Stream-to-UART serializer. Successor to the fixed 8N1 transmitter.
- Adds runtime-selectable parity (none/even/odd/mark), one or two stop bits, break generation and a frame-done strobe.
- Sits between a byte/word stream source and the txd pin. Bit timing is derived from the same prescale convention: one bit lasts prescale*8 clk cycles.

Parameters:
- DATA_WIDTH, 8, data bits per frame (5..9), sent LSB first
- FIFO_DEPTH, 16, input FIFO entries (power of 2, >=2); used only with UART_TX_FIFO_EN

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- s_axis_tdata  in  DATA_WIDTH  word to transmit
- s_axis_tvalid  in  1  source has a word
- s_axis_tready  out  1  block accepts the word this cycle
- txd  out  1  serial output, idle high
- busy  out  1  frame in progress or words pending
- tx_done  out  1  one-cycle pulse at end of each frame's last stop bit
- fifo_count  out  $clog2(FIFO_DEPTH)+1  words buffered (constant 0 without FIFO)
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 mark (parity bit = 1)
- stop2  in  1  0: one stop bit, 1: two stop bits
- break_req  in  1  request line break
- prescale  in  16  bit period = prescale*8 clocks; prescale 0 is treated as 1

Behaviour:
- Reset values (asynchronous): txd=1, s_axis_tready=0, busy=0, tx_done=0, fifo_count=0, FSM=IDLE, all counters 0. s_axis_tready may rise on the first clock after reset release.
- All outputs are registered. There is no combinational path from s_axis_tvalid to s_axis_tready.
- Transfer occurs on a clock edge where tvalid && tready.
- FSM states: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE:
  - txd=1.
  - If break_req=1, go to BREAK; this takes priority over pending data.
  - Otherwise, if a word is available, latch data, parity_mode, stop2 and prescale into frame registers and go to START.
  - Config inputs changed mid-frame have no effect until the next frame.
- START: txd=0 for one bit period, starting the cycle after acceptance/pop.
- DATA: DATA_WIDTH bits, LSB first, one bit period each.
- PARITY: entered only if latched parity_mode != 00.
  - Even: parity bit = XOR of data.
  - Odd: parity bit = inverted XOR of data.
  - Mark: parity bit = 1.
- STOP: txd=1 for one bit period (stop2=0) or two bit periods (stop2=1).
  - tx_done pulses on the final cycle of the last stop bit.
  - Next state is IDLE.
  - A following queued word starts its START bit on the very next cycle, so there is no gap between frames.
- BREAK: txd=0 while break_req=1, and tready=0.
  - On deassert, hold txd=1 for one full bit period (stop-bit time), then go to IDLE.
  - break_req during a frame is ignored until the frame completes.
- Bit timer: 19-bit down-counter loaded with (prescale_latched<<3)-1 at each bit start; the bit advances when the counter reaches 0.
- busy: 1 whenever FSM != IDLE or fifo_count != 0.
- Frame length in clocks = 8*prescale*(1 + DATA_WIDTH + P + S), where P = 0 or 1 (parity) and S = 1 or 2 (stop bits).

Optional Feature:
- Macro: UART_TX_FIFO_EN
- Defined:
  - FIFO_DEPTH-entry synchronous FIFO in front of the FSM.
  - s_axis_tready = !full, registered; it may stay high every cycle, allowing back-to-back acceptance.
  - The FSM pops in IDLE.
  - fifo_count reflects occupancy; it updates the cycle after each push/pop, and a simultaneous push and pop leaves it unchanged.
  - When full, tready=0 and tvalid is held by the source.
- Undefined:
  - No FIFO; fifo_count=0.
  - s_axis_tready=1 only in IDLE with break_req=0, and drops to 0 the cycle after acceptance.
  - At most one word is in flight.

Test Plan:
- prescale=1, parity 00, stop2=0: send 0xA5 → txd = 0,1,0,1,0,0,1,0,1,1, each held 8 clks. Frame is 80 clks. tx_done pulses at clk 80. busy is 1 throughout.
- Same settings with parity 01 then 10, 0xA5 (popcount 4) → parity bit 0 then 1. Frame is 88 clks.
- stop2=1, parity 11, 0x00 → bits 0,00000000,1,1,1. Frame is 96 clks. Changing stop2/parity_mode mid-frame does not alter the frame.
- break_req=1 while idle for 50 clks → txd=0 for 50 clks, tready=0. After release, txd=1 for 8 clks, then the next word is accepted.
- Assert rst mid-DATA of 0xFF → txd=1, busy=0, tx_done=0 immediately. After release, the next word transmits as a complete, correct frame.
- With UART_TX_FIFO_EN, FIFO_DEPTH=4: push 0x11,0x22,0x33,0x44,0x55 on consecutive cycles → first 4 accepted, fifo_count peaks at 4 or 3 per pop timing, tready drops when full. The 5 frames go out contiguous with no idle cycles between them, with 5 tx_done pulses 80 clks apart.
